// File: rtl/control_sequencer.sv
// control_sequencer
//   Microsequencer that drives the load/output enables of the datapath
//   registers (PC, MAR, IR, A, B, OUT). It fetches in T1-T2 and decodes the
//   opcode held in the IR during T3-T4. It emits one control word per T-state.
//
// Ports
//   clk       in   system clock, all state updates on posedge
//   i_reset   in   synchronous active-high reset, has priority over clk_en
//   clk_en    in   state advances only on edges where clk_en=1
//   i_opcode  in   IR contents, only decoded in T3/T4
//   o_ctrl    out  12-bit control word, combinational from state and i_opcode
//                  [0] pc_out  [1] pc_inc  [2] mar_load [3] mem_out
//                  [4] ir_load [5] a_load  [6] a_out    [7] b_load
//                  [8] alu_out [9] out_load [10] mem_write [11] pc_load
//   o_tstate  out  current T-state 1..4, 0 while halted
//   o_halted  out  1 while in HALT
//
// state | meaning
// ------+--------------------------------------------------------------
// T1    | fetch: PC onto bus, load MAR
// T2    | fetch: memory onto bus, load IR, increment PC
// T3    | execute step 1, decoded from i_opcode
// T4    | execute step 2, only for MVI A and JMP
// HALT  | all enables off; left only through i_reset

module control_sequencer #(
  parameter int                    OPCODE_WIDTH = 8,
  parameter logic [OPCODE_WIDTH-1:0] HLT_OPCODE = 8'h76
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    clk_en,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic [11:0]             o_ctrl,
  output logic [2:0]              o_tstate,
  output logic                    o_halted
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [11:0] CW_NONE  = 12'h000;
  localparam logic [11:0] CW_FETCH = 12'h005;  // pc_out | mar_load
  localparam logic [11:0] CW_IRLD  = 12'h01A;  // mem_out | ir_load | pc_inc
  localparam logic [11:0] CW_ADD   = 12'h120;  // alu_out | a_load
  localparam logic [11:0] CW_MOVBA = 12'h0C0;  // a_out | b_load
  localparam logic [11:0] CW_OUT   = 12'h240;  // a_out | out_load
  localparam logic [11:0] CW_MVI4  = 12'h02A;  // mem_out | a_load | pc_inc
  localparam logic [11:0] CW_JMP4  = 12'h808;  // mem_out | pc_load

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h80;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV = 8'h47;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 8'hD3;
  localparam logic [OPCODE_WIDTH-1:0] OP_MVI = 8'h3E;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 8'hC3;

  state_e state_q, state_d;
  state_e step_nxt;  // where the state goes if this edge is enabled

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_T1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    step_nxt = state_q;
    o_ctrl   = CW_NONE;
    o_tstate = 3'd0;
    o_halted = 1'b0;

    unique case (state_q)
      S_T1: begin
        o_ctrl   = CW_FETCH;
        o_tstate = 3'd1;
        step_nxt = S_T2;
      end
      S_T2: begin
        o_ctrl   = CW_IRLD;
        o_tstate = 3'd2;
        step_nxt = S_T3;
      end
      S_T3: begin
        o_tstate = 3'd3;
        step_nxt = S_T1;
        // HLT is a parameter, so it is matched ahead of the fixed opcodes
        if (i_opcode == HLT_OPCODE) begin
          step_nxt = S_HALT;
        end else begin
          case (i_opcode)
            OP_NOP: o_ctrl = CW_NONE;
            OP_ADD: o_ctrl = CW_ADD;
            OP_MOV: o_ctrl = CW_MOVBA;
            OP_OUT: o_ctrl = CW_OUT;
            OP_MVI, OP_JMP: begin
              o_ctrl   = CW_FETCH;
              step_nxt = S_T4;
            end
            default: o_ctrl = CW_NONE;
          endcase
        end
      end
      S_T4: begin
        o_tstate = 3'd4;
        step_nxt = S_T1;
        // an opcode that changed under us since T3 gets no enables here
        if (i_opcode == OP_MVI) begin
          o_ctrl = CW_MVI4;
        end else if (i_opcode == OP_JMP) begin
          o_ctrl = CW_JMP4;
        end
      end
      S_HALT: begin
        o_halted = 1'b1;
        step_nxt = S_HALT;
      end
      default: begin
        step_nxt = S_T1;
      end
    endcase

    state_d = clk_en ? step_nxt : state_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed vectors, scoreboard queue of
// expected per-cycle outputs, independent monitor comparing at negedge.

module tb_control_sequencer;

  logic        clk;
  logic        i_reset;
  logic        clk_en;
  logic [7:0]  i_opcode;
  logic [11:0] o_ctrl;
  logic [2:0]  o_tstate;
  logic        o_halted;

  control_sequencer dut (
    .clk      (clk),
    .i_reset  (i_reset),
    .clk_en   (clk_en),
    .i_opcode (i_opcode),
    .o_ctrl   (o_ctrl),
    .o_tstate (o_tstate),
    .o_halted (o_halted)
  );

  typedef struct {
    logic [2:0]  t;
    logic [11:0] c;
    logic        h;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every cycle is an output beat; compare against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   drivers;
      e = exp_q.pop_front();
      checks++;
      if (o_tstate !== e.t || o_ctrl !== e.c || o_halted !== e.h) begin
        errors++;
        $display("FAIL %s: got tstate=%0d ctrl=%03h halted=%0b, want tstate=%0d ctrl=%03h halted=%0b",
                 e.name, o_tstate, o_ctrl, o_halted, e.t, e.c, e.h);
      end
      drivers = int'(o_ctrl[0]) + int'(o_ctrl[3]) + int'(o_ctrl[6]) + int'(o_ctrl[8]);
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL %s_bus: got %0d bus drivers (ctrl=%03h), want at most 1",
                 e.name, drivers, o_ctrl);
      end
    end
  end

  // Apply inputs for one cycle, record the outputs expected in that cycle,
  // then advance past the next posedge.
  task automatic cyc(input logic rst, input logic en, input logic [7:0] op,
                     input logic [2:0] t, input logic [11:0] c, input logic h,
                     input string name);
    exp_t e;
    i_reset  = rst;
    clk_en   = en;
    i_opcode = op;
    e.t = t; e.c = c; e.h = h; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_reset  = 1'b1;
    clk_en   = 1'b1;
    i_opcode = 8'h00;
    @(posedge clk);
    #1;

    // 1: reset then fetch, NOP
    cyc(0, 1, 8'h00, 1, 12'h005, 0, "reset_t1");
    cyc(0, 1, 8'h00, 2, 12'h01A, 0, "fetch_t2");
    cyc(0, 1, 8'h00, 3, 12'h000, 0, "nop_t3");

    // 2: MVI A, four cycles then back to T1
    cyc(0, 1, 8'h3E, 1, 12'h005, 0, "mvi_t1");
    cyc(0, 1, 8'h3E, 2, 12'h01A, 0, "mvi_t2");
    cyc(0, 1, 8'h3E, 3, 12'h005, 0, "mvi_t3");
    cyc(0, 1, 8'h3E, 4, 12'h02A, 0, "mvi_t4");
    cyc(0, 1, 8'h3E, 1, 12'h005, 0, "mvi_back_t1");

    // 3: stall in T2 for 5 cycles
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h3E, 2, 12'h01A, 0, "stall_t2");
    cyc(0, 1, 8'h3E, 2, 12'h01A, 0, "stall_release");
    cyc(0, 1, 8'h3E, 3, 12'h005, 0, "stall_t3");
    cyc(0, 1, 8'h3E, 4, 12'h02A, 0, "stall_t4");

    // 5: JMP, unknown opcode, ADD/MOV/OUT sweep
    cyc(0, 1, 8'hC3, 1, 12'h005, 0, "jmp_t1");
    cyc(0, 1, 8'hC3, 2, 12'h01A, 0, "jmp_t2");
    cyc(0, 1, 8'hC3, 3, 12'h005, 0, "jmp_t3");
    cyc(0, 1, 8'hC3, 4, 12'h808, 0, "jmp_t4");
    cyc(0, 1, 8'hFF, 1, 12'h005, 0, "unk_t1");
    cyc(0, 1, 8'hFF, 2, 12'h01A, 0, "unk_t2");
    cyc(0, 1, 8'hFF, 3, 12'h000, 0, "unk_t3");
    cyc(0, 1, 8'h80, 1, 12'h005, 0, "add_t1");
    cyc(0, 1, 8'h80, 2, 12'h01A, 0, "add_t2");
    cyc(0, 1, 8'h80, 3, 12'h120, 0, "add_t3");
    cyc(0, 1, 8'h47, 1, 12'h005, 0, "mov_t1");
    cyc(0, 1, 8'h47, 2, 12'h01A, 0, "mov_t2");
    cyc(0, 1, 8'h47, 3, 12'h0C0, 0, "mov_t3");
    cyc(0, 1, 8'hD3, 1, 12'h005, 0, "out_t1");
    cyc(0, 1, 8'hD3, 2, 12'h01A, 0, "out_t2");
    cyc(0, 1, 8'hD3, 3, 12'h240, 0, "out_t3");

    // stalled T3 with opcode changing: o_ctrl follows combinationally
    cyc(0, 1, 8'h80, 1, 12'h005, 0, "chg_t1");
    cyc(0, 1, 8'h80, 2, 12'h01A, 0, "chg_t2");
    cyc(0, 0, 8'h80, 3, 12'h120, 0, "chg_t3_add");
    cyc(0, 0, 8'h47, 3, 12'h0C0, 0, "chg_t3_mov");
    cyc(0, 1, 8'hD3, 3, 12'h240, 0, "chg_t3_out");

    // 6: reset in T4 of MVI with clk_en=0
    cyc(0, 1, 8'h3E, 1, 12'h005, 0, "rst4_t1");
    cyc(0, 1, 8'h3E, 2, 12'h01A, 0, "rst4_t2");
    cyc(0, 1, 8'h3E, 3, 12'h005, 0, "rst4_t3");
    cyc(1, 0, 8'h3E, 4, 12'h02A, 0, "rst4_t4");
    cyc(0, 1, 8'h00, 1, 12'h005, 0, "rst4_after");
    cyc(0, 1, 8'h00, 2, 12'h01A, 0, "rst4_t2b");
    cyc(0, 1, 8'h00, 3, 12'h000, 0, "rst4_nop");

    // 4: HLT, stays halted regardless of clk_en and opcode
    cyc(0, 1, 8'h76, 1, 12'h005, 0, "hlt_t1");
    cyc(0, 1, 8'h76, 2, 12'h01A, 0, "hlt_t2");
    cyc(0, 1, 8'h76, 3, 12'h000, 0, "hlt_t3");
    for (int i = 0; i < 22; i++) begin
      logic [7:0] op;
      op = (i % 3 == 0) ? 8'h3E : ((i % 3 == 1) ? 8'hC3 : 8'h80);
      cyc(0, logic'(i % 2), op, 0, 12'h000, 1, "halted");
    end
    cyc(1, 0, 8'h00, 0, 12'h000, 1, "halt_rst");
    cyc(0, 1, 8'h00, 1, 12'h005, 0, "halt_exit_t1");
    cyc(0, 1, 8'h00, 2, 12'h01A, 0, "halt_exit_t2");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
